// File: rtl/dcache_miss_ctrl.sv
// ---------------------------------------------------------------------------
// dcache_miss_ctrl
//
// Request sequencer for a direct-mapped, write-back data cache. It takes one
// CPU load/store at a time and looks up the tag. Hits are answered straight
// from the cache RAM. On a miss, a dirty victim is first written back to
// memory as one full-line beat. The line is then refilled word by word, and
// tag, data and valid/dirty are written back in a single REFILL cycle.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   req_*               : CPU request (valid/ready handshake; ready only in IDLE)
//   resp_valid/rdata    : one-cycle completion pulse, load data (0 for stores)
//   ram_a / ram_dpra    : cache RAM index (data port / tag+flag port, equal)
//   ram_wen, ram_wen_dv : tag write enable, valid/dirty write enable
//   ram_we, ram_dina    : per-byte line write enables and line write data
//   ram_tag_w, ram_w_*  : tag and flag write data
//   ram_dpo, ram_cache_*: stored tag/flags (combinational read)
//   ram_douta           : stored line (registered read, valid one cycle later)
//   mem_wr_*            : victim writeback (req held until mem_wr_ready)
//   mem_rd_*            : refill request and ascending word beats
// ---------------------------------------------------------------------------
module dcache_miss_ctrl #(
  parameter int INDEX_SIZE    = 7,
  parameter int WORD_OFF_SIZE = 3,
  parameter int TAG_SIZE      = 32 - INDEX_SIZE - WORD_OFF_SIZE - 2
) (
  input  logic                              clk,
  input  logic                              reset,
  // CPU side
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_wr,
  input  logic [31:0]                       req_addr,
  input  logic [3:0]                        req_wstrb,
  input  logic [31:0]                       req_wdata,
  output logic                              resp_valid,
  output logic [31:0]                       resp_rdata,
  // cache RAM side
  output logic [INDEX_SIZE-1:0]             ram_a,
  output logic [INDEX_SIZE-1:0]             ram_dpra,
  output logic                              ram_wen,
  output logic                              ram_wen_dv,
  output logic [4*(2**WORD_OFF_SIZE)-1:0]   ram_we,
  output logic [TAG_SIZE-1:0]               ram_tag_w,
  output logic [32*(2**WORD_OFF_SIZE)-1:0]  ram_dina,
  output logic                              ram_w_valid,
  output logic                              ram_w_dirty,
  input  logic [TAG_SIZE-1:0]               ram_dpo,
  input  logic [32*(2**WORD_OFF_SIZE)-1:0]  ram_douta,
  input  logic                              ram_cache_valid,
  input  logic                              ram_cache_dirty,
  // memory side
  output logic                              mem_wr_req,
  output logic [31:0]                       mem_wr_addr,
  output logic [32*(2**WORD_OFF_SIZE)-1:0]  mem_wr_data,
  input  logic                              mem_wr_ready,
  output logic                              mem_rd_req,
  output logic [31:0]                       mem_rd_addr,
  input  logic                              mem_rd_ready,
  input  logic                              mem_rd_valid,
  input  logic [31:0]                       mem_rd_data
);

  localparam int WPL    = 2**WORD_OFF_SIZE;
  localparam int LINE_W = 32 * WPL;
  localparam int IDX_LO = WORD_OFF_SIZE + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WB, S_RF_REQ, S_RF_DATA, S_REFILL
  } state_e;

  state_e                   state_q;
  logic [31:2]              addr_q;
  logic                     wr_q;
  logic [3:0]               wstrb_q;
  logic [31:0]              wdata_q;
  logic [TAG_SIZE-1:0]      victim_tag_q;
  // Holds the victim line during WB, then collects refill beats.
  logic [LINE_W-1:0]        line_q;
  logic [WORD_OFF_SIZE-1:0] cnt_q;

  logic [TAG_SIZE-1:0]      tag_l;
  logic [INDEX_SIZE-1:0]    idx_l;
  logic [WORD_OFF_SIZE-1:0] off_l;
  logic                     hit;
  logic [LINE_W-1:0]        merged_line;
  logic [4*WPL-1:0]         hit_we;
  logic                     unused_addr_bits;

  assign tag_l = addr_q[31 -: TAG_SIZE];
  assign idx_l = addr_q[IDX_LO +: INDEX_SIZE];
  assign off_l = addr_q[2 +: WORD_OFF_SIZE];
  assign hit   = ram_cache_valid && (ram_dpo == tag_l);

  // Byte-lane address bits never reach the cache; word granularity only.
  assign unused_addr_bits = ^req_addr[1:0];

  // Per-byte store merge into the refilled line, and per-byte write enables
  // for a store hit. Both only touch the addressed word.
  for (genvar gi = 0; gi < WPL; gi++) begin : g_word
    for (genvar bi = 0; bi < 4; bi++) begin : g_byte
      assign hit_we[4*gi+bi] = wstrb_q[bi] && (off_l == WORD_OFF_SIZE'(gi));
      assign merged_line[32*gi+8*bi +: 8] =
        (wr_q && hit_we[4*gi+bi]) ? wdata_q[8*bi +: 8] : line_q[32*gi+8*bi +: 8];
    end
  end

  // Memory requests decode straight from the state register, so they drop
  // the cycle after a reset.
  assign mem_wr_req  = (state_q == S_WB);
  assign mem_wr_addr = {victim_tag_q, idx_l, {IDX_LO{1'b0}}};
  assign mem_wr_data = line_q;
  assign mem_rd_req  = (state_q == S_RF_REQ);
  assign mem_rd_addr = {tag_l, idx_l, {IDX_LO{1'b0}}};

  assign req_ready = (state_q == S_IDLE);
  assign ram_dpra  = ram_a;

  always_comb begin
    // In IDLE the index comes from the live request, so the 1-cycle data
    // read is already valid when LOOKUP starts.
    ram_a       = (state_q == S_IDLE) ? req_addr[IDX_LO +: INDEX_SIZE] : idx_l;
    resp_valid  = 1'b0;
    resp_rdata  = '0;
    ram_wen     = 1'b0;
    ram_wen_dv  = 1'b0;
    ram_we      = '0;
    ram_tag_w   = '0;
    ram_dina    = '0;
    ram_w_valid = 1'b0;
    ram_w_dirty = 1'b0;
    // Reset suppresses any write or completion of the in-flight operation.
    if (!reset) begin
      case (state_q)
        S_LOOKUP: begin
          if (hit) begin
            resp_valid = 1'b1;
            if (wr_q) begin
              ram_we      = hit_we;
              ram_dina    = {WPL{wdata_q}};
              ram_wen_dv  = 1'b1;
              ram_w_valid = 1'b1;
              ram_w_dirty = 1'b1;
            end else begin
              resp_rdata = ram_douta[32*off_l +: 32];
            end
          end
        end
        S_REFILL: begin
          resp_valid  = 1'b1;
          resp_rdata  = wr_q ? 32'h0 : line_q[32*off_l +: 32];
          ram_we      = '1;
          ram_dina    = merged_line;
          ram_wen     = 1'b1;
          ram_tag_w   = tag_l;
          ram_wen_dv  = 1'b1;
          ram_w_valid = 1'b1;
          ram_w_dirty = wr_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wr_q         <= 1'b0;
      wstrb_q      <= '0;
      wdata_q      <= '0;
      victim_tag_q <= '0;
      line_q       <= '0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr[31:2];
            wr_q    <= req_wr;
            wstrb_q <= req_wstrb;
            wdata_q <= req_wdata;
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            state_q <= S_IDLE;
          end else begin
            line_q       <= ram_douta;
            victim_tag_q <= ram_dpo;
            state_q      <= (ram_cache_valid && ram_cache_dirty) ? S_WB : S_RF_REQ;
          end
        end
        S_WB: begin
          if (mem_wr_ready) state_q <= S_RF_REQ;
        end
        S_RF_REQ: begin
          if (mem_rd_ready) begin
            cnt_q   <= '0;
            state_q <= S_RF_DATA;
          end
        end
        S_RF_DATA: begin
          if (mem_rd_valid) begin
            line_q[32*cnt_q +: 32] <= mem_rd_data;
            cnt_q                  <= cnt_q + WORD_OFF_SIZE'(1);
            if (cnt_q == WORD_OFF_SIZE'(WPL-1)) state_q <= S_REFILL;
          end
        end
        S_REFILL: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dcache_miss_ctrl
//
// The cache RAM and the backing memory are modelled here. The reference is an
// architectural memory: a load must return the last value stored to that word
// (or the word's initial content), a store returns 0. A write-back cache must
// be transparent to the CPU, so every response is checked against that view.
// Expected responses are queued at issue time and popped by a monitor on
// resp_valid.
// ---------------------------------------------------------------------------
module tb_dcache_miss_ctrl;

  localparam int INDEX_SIZE    = 7;
  localparam int WORD_OFF_SIZE = 3;
  localparam int TAG_SIZE      = 32 - INDEX_SIZE - WORD_OFF_SIZE - 2;
  localparam int WPL           = 2**WORD_OFF_SIZE;
  localparam int LINES         = 2**INDEX_SIZE;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic                    req_valid = 1'b0, req_ready, req_wr = 1'b0;
  logic [31:0]             req_addr = '0, req_wdata = '0;
  logic [3:0]              req_wstrb = '0;
  logic                    resp_valid;
  logic [31:0]             resp_rdata;
  logic [INDEX_SIZE-1:0]   ram_a, ram_dpra;
  logic                    ram_wen, ram_wen_dv, ram_w_valid, ram_w_dirty;
  logic [4*WPL-1:0]        ram_we;
  logic [TAG_SIZE-1:0]     ram_tag_w, ram_dpo;
  logic [32*WPL-1:0]       ram_dina, ram_douta;
  logic                    ram_cache_valid, ram_cache_dirty;
  logic                    mem_wr_req, mem_wr_ready = 1'b0;
  logic [31:0]             mem_wr_addr;
  logic [32*WPL-1:0]       mem_wr_data;
  logic                    mem_rd_req, mem_rd_ready = 1'b0, mem_rd_valid = 1'b0;
  logic [31:0]             mem_rd_addr, mem_rd_data = '0;

  dcache_miss_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .ram_a(ram_a), .ram_dpra(ram_dpra), .ram_wen(ram_wen), .ram_wen_dv(ram_wen_dv),
    .ram_we(ram_we), .ram_tag_w(ram_tag_w), .ram_dina(ram_dina),
    .ram_w_valid(ram_w_valid), .ram_w_dirty(ram_w_dirty),
    .ram_dpo(ram_dpo), .ram_douta(ram_douta),
    .ram_cache_valid(ram_cache_valid), .ram_cache_dirty(ram_cache_dirty),
    .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_ready(mem_wr_ready),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_ready(mem_rd_ready),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data)
  );

  // ---------------- cache RAM model ----------------
  logic                ram_clear = 1'b1;
  logic [TAG_SIZE-1:0] tmem  [LINES];
  logic                vmem  [LINES];
  logic                dflag [LINES];
  logic [32*WPL-1:0]   dmem  [LINES];

  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < LINES; i++) begin
        tmem[i] <= '0; vmem[i] <= 1'b0; dflag[i] <= 1'b0; dmem[i] <= '0;
      end
      ram_douta <= '0;
    end else begin
      ram_douta <= dmem[ram_a];
      for (int b = 0; b < 4*WPL; b++)
        if (ram_we[b]) dmem[ram_a][8*b +: 8] <= ram_dina[8*b +: 8];
      if (ram_wen) tmem[ram_a] <= ram_tag_w;
      if (ram_wen_dv) begin
        vmem[ram_a]  <= ram_w_valid;
        dflag[ram_a] <= ram_w_dirty;
      end
    end
  end
  assign ram_dpo         = tmem[ram_dpra];
  assign ram_cache_valid = vmem[ram_dpra];
  assign ram_cache_dirty = dflag[ram_dpra];

  // ---------------- reference: architectural and backing memory ----------------
  logic [31:0] arch [int unsigned];
  logic [31:0] bmem [int unsigned];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a[31:5] == 27'h82) return 32'hA0 + {29'd0, a[4:2]};
    return {a[15:0], ~a[15:0]};
  endfunction
  function automatic logic [31:0] arch_rd(input logic [31:0] a);
    int unsigned k = a >> 2;
    return arch.exists(k) ? arch[k] : init_word(a);
  endfunction
  function automatic logic [31:0] bmem_rd(input logic [31:0] a);
    int unsigned k = a >> 2;
    return bmem.exists(k) ? bmem[k] : init_word(a);
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  typedef struct packed { logic wr; logic [31:0] addr; logic [31:0] rdata; } exp_t;
  exp_t exp_q[$];

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (mem_wr_req || mem_rd_req)
          chk("single_mem_req", mem_wr_req && mem_rd_req, 0);
        if (ram_wen || ram_wen_dv || (|ram_we))
          chk("ram_write_with_resp", resp_valid, 1);
        if (resp_valid) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_resp: got rdata %0h required no response", resp_rdata);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("resp_rdata wr=%0d addr=%h", e.wr, e.addr), resp_rdata, e.rdata);
          end
        end
      end
    end
  end

  // ---------------- memory responder ----------------
  int          ms = 0;             // 0 idle, 1 wb stall, 2 rd req stall, 3 rd beats
  int          wait_cnt = 0, beat = 0;
  int          wb_count = 0, rd_count = 0;
  int          wb_stall_force = -1;
  logic [31:0] wb_addr = '0, rd_addr = '0, last_wb_addr = '0, last_rd_addr = '0;
  logic [32*WPL-1:0] wb_data = '0;

  task automatic wb_commit();
    for (int i = 0; i < WPL; i++) bmem[(wb_addr >> 2) + i] = wb_data[32*i +: 32];
  endtask

  initial begin : mem_model
    forever begin
      @(negedge clk);
      mem_wr_ready = 1'b0; mem_rd_ready = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
      if (reset) begin
        ms = 0;
      end else begin
        case (ms)
          0: begin
            if (mem_wr_req) begin
              wb_addr = mem_wr_addr; wb_data = mem_wr_data; last_wb_addr = wb_addr;
              wb_count++;
              chk("wb_addr_aligned", wb_addr[4:0], 0);
              wait_cnt = (wb_stall_force >= 0) ? wb_stall_force : int'($urandom_range(0, 3));
              if (wait_cnt == 0) begin mem_wr_ready = 1'b1; wb_commit(); end
              else ms = 1;
            end else if (mem_rd_req) begin
              rd_addr = mem_rd_addr; last_rd_addr = rd_addr;
              rd_count++;
              wait_cnt = int'($urandom_range(0, 2));
              if (wait_cnt == 0) begin mem_rd_ready = 1'b1; beat = 0; ms = 3; end
              else ms = 2;
            end
          end
          1: begin
            chk("wb_req_held", mem_wr_req, 1);
            chk("wb_addr_stable", mem_wr_addr, wb_addr);
            chk("wb_data_stable", mem_wr_data, wb_data);
            wait_cnt--;
            if (wait_cnt == 0) begin mem_wr_ready = 1'b1; wb_commit(); ms = 0; end
          end
          2: begin
            chk("rd_req_held", mem_rd_req, 1);
            chk("rd_addr_stable", mem_rd_addr, rd_addr);
            wait_cnt--;
            if (wait_cnt == 0) begin mem_rd_ready = 1'b1; beat = 0; ms = 3; end
          end
          default: begin
            chk("rd_req_dropped", mem_rd_req, 0);
            if ($urandom_range(0, 3) != 0) begin
              mem_rd_valid = 1'b1;
              mem_rd_data  = bmem_rd(rd_addr + 32'(4*beat));
              beat++;
              if (beat == WPL) ms = 0;
            end
          end
        endcase
      end
    end
  end

  // ---------------- driver ----------------
  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 500) begin @(negedge clk); n++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_ready_timeout: got req_ready=0 required 1 within 500 cycles");
    end
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr,
                       input logic [3:0] strb, input logic [31:0] wdata);
    exp_t        e;
    logic [31:0] w;
    wait_ready();
    e.wr = wr; e.addr = addr;
    if (wr) begin
      w = arch_rd(addr);
      for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = wdata[8*b +: 8];
      arch[addr >> 2] = w;
      e.rdata = '0;
    end else begin
      e.rdata = arch_rd(addr);
    end
    exp_q.push_back(e);
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wstrb = strb; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL resp_timeout: got %0d responses pending required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin : main
    int rdc, wbc, n, k;
    logic [31:0] a;
    repeat (3) @(negedge clk);
    ram_clear = 1'b0;
    reset = 1'b0;

    // reset state
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mem_wr_req", mem_wr_req, 0);
    chk("rst_mem_rd_req", mem_rd_req, 0);
    chk("rst_ram_wen", {ram_wen, ram_wen_dv}, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_mem_addrs", {mem_wr_addr, mem_rd_addr}, 0);
    chk("rst_mem_wr_data", mem_wr_data, 0);

    // clean read miss
    rdc = rd_count; wbc = wb_count;
    issue(1'b0, 32'h0000_1040, 4'h0, 32'h0);
    wait_done();
    @(negedge clk);
    chk("miss_rd_addr", last_rd_addr, 32'h0000_1040);
    chk("miss_rd_count", rd_count, rdc + 1);
    chk("miss_no_wb", wb_count, wbc);
    chk("miss_tag", tmem[2], 20'h00001);
    chk("miss_flags", {vmem[2], dflag[2]}, 2'b10);

    // read hit
    rdc = rd_count; wbc = wb_count;
    issue(1'b0, 32'h0000_104C, 4'h0, 32'h0);
    chk("hit_latency", resp_valid, 1);
    wait_done();
    chk("hit_no_mem", {rd_count, wb_count}, {rdc, wbc});

    // store hit, then load back
    issue(1'b1, 32'h0000_1044, 4'b0011, 32'h1234_5678);
    chk("st_hit_resp", resp_valid, 1);
    chk("st_hit_we", ram_we, 32'h0000_0030);
    chk("st_hit_dv", {ram_wen, ram_wen_dv, ram_w_valid, ram_w_dirty}, 4'b0111);
    wait_done();
    issue(1'b0, 32'h0000_1044, 4'h0, 32'h0);
    wait_done();

    // dirty eviction with a 3-cycle writeback stall
    wb_stall_force = 3; wbc = wb_count;
    issue(1'b0, 32'h0000_2040, 4'h0, 32'h0);
    wait_done();
    wb_stall_force = -1;
    @(negedge clk);
    chk("evict_wb_count", wb_count, wbc + 1);
    chk("evict_wb_addr", last_wb_addr, 32'h0000_1040);
    chk("evict_rd_addr", last_rd_addr, 32'h0000_2040);
    chk("evict_tag", tmem[2], 20'h00002);
    chk("evict_flags", {vmem[2], dflag[2]}, 2'b10);
    // the written-back store must come back through memory
    issue(1'b0, 32'h0000_1044, 4'h0, 32'h0);
    wait_done();

    // store miss to a clean (invalid) victim
    issue(1'b1, 32'h0000_3000, 4'b0110, 32'hDEAD_BEEF);
    wait_done();
    @(negedge clk);
    chk("stmiss_tag", tmem[0], 20'h00003);
    chk("stmiss_flags", {vmem[0], dflag[0]}, 2'b11);
    chk("stmiss_word", dmem[0][31:0], arch_rd(32'h0000_3000));

    // reset after 4 refill beats
    wait_ready();
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h0000_5020;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0; k = 0;
    while (n < 4 && k < 200) begin
      @(posedge clk); #1;
      if (mem_rd_valid) n++;
      k++;
    end
    chk("rst_mid_beats_seen", n, 4);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_ready", req_ready, 1);
    chk("rst_mid_rd_req", mem_rd_req, 0);
    chk("rst_mid_no_write", {ram_wen, ram_wen_dv, resp_valid}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_line_untouched", vmem[1], 0);

    // randomized traffic over a few aliasing lines
    for (int i = 0; i < 250; i++) begin
      a = {20'($urandom_range(1, 5)), 7'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'b00};
      if ($urandom_range(0, 2) == 0)
        issue(1'b1, a, 4'($urandom_range(1, 15)), $urandom);
      else
        issue(1'b0, a, 4'h0, 32'h0);
    end
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_miss_ctrl.md
Name: dcache_miss_ctrl

Overview:
- Request-sequencing FSM for the direct-mapped write-back data cache RAM: tag array, per-byte data banks with 1-cycle read, and valid/dirty flag array.
- Accepts one CPU load/store at a time and performs the tag lookup.
- Serves hits directly.
- On a miss: writes back a dirty victim line as one full-line beat, refills the line word-by-word from memory, then updates tag, data and valid/dirty.
- Sits between the LSU and the cache RAM on one side, and the memory/AXI bridge on the other.

Parameters:
- INDEX_SIZE, 7, line index bits (lines = 2**INDEX_SIZE).
- WORD_OFF_SIZE, 3, word-offset bits (WPL = 2**WORD_OFF_SIZE words per line).
- TAG_SIZE, 32-INDEX_SIZE-WORD_OFF_SIZE-2, tag bits.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high. Top level drives the RAM's resetn = ~reset.
- req_valid  in  1  CPU request valid.
- req_ready  out  1  high only in IDLE.
- req_wr  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address. Tag = [31:32-TAG_SIZE], index = next INDEX_SIZE bits, word offset = next WORD_OFF_SIZE bits.
- req_wstrb  in  4  store byte enables.
- req_wdata  in  32  store data.
- resp_valid  out  1  one-cycle completion pulse; no backpressure.
- resp_rdata  out  32  load data, valid with resp_valid; 0 for stores.
- ram_a  out  INDEX_SIZE  RAM write / data-read index.
- ram_dpra  out  INDEX_SIZE  tag/flag read index (always equal to ram_a).
- ram_wen  out  1  tag write enable.
- ram_wen_dv  out  1  valid/dirty write enable.
- ram_we  out  4*WPL  data byte write enables.
- ram_tag_w  out  TAG_SIZE  tag write data.
- ram_dina  out  32*WPL  line write data.
- ram_w_valid, ram_w_dirty  out  1 each  flag write data.
- ram_dpo  in  TAG_SIZE  stored tag (combinational read).
- ram_douta  in  32*WPL  stored line (1-cycle read).
- ram_cache_valid, ram_cache_dirty  in  1 each  stored flags.
- mem_wr_req  out  1  writeback request.
- mem_wr_addr  out  32  line-aligned writeback address.
- mem_wr_data  out  32*WPL  victim line.
- mem_wr_ready  in  1  writeback accepted (done).
- mem_rd_req  out  1  refill request.
- mem_rd_addr  out  32  line-aligned refill address.
- mem_rd_ready  in  1  refill request accepted.
- mem_rd_valid  in  1  refill data beat.
- mem_rd_data  in  32  refill word, ascending word order.

Behaviour:
- Reset values:
  - State IDLE; beat counter 0.
  - All outputs 0 except req_ready=1.
  - Request latch cleared.
- Reset in any state aborts the operation: no RAM write, no resp_valid, memory requests drop the next cycle.
- Latching in IDLE:
  - ram_a and ram_dpra are driven from req_addr index combinationally.
  - On req_valid: latch addr/wr/wstrb/wdata; go to LOOKUP.
- Index hold: in every non-IDLE state, ram_a and ram_dpra come from the latched index.
- LOOKUP (ram_douta is now valid): hit = ram_cache_valid && (ram_dpo == latched tag).
  - Load hit: resp_valid=1, resp_rdata = addressed word of ram_douta; go to IDLE. Latency is 1 cycle after acceptance.
  - Store hit:
    - ram_we[4*off+b] = wstrb[b]; ram_dina = wdata replicated WPL times.
    - ram_wen_dv=1, w_valid=1, w_dirty=1; ram_wen=0.
    - resp_valid=1; go to IDLE.
  - Miss:
    - Capture victim line and victim tag.
    - If ram_cache_valid && ram_cache_dirty, go to WB; otherwise go to RF_REQ.
- WB:
  - mem_wr_req=1; mem_wr_addr = {victim tag, index, 0}; mem_wr_data = captured line.
  - Signals are held stable until a cycle with mem_wr_ready=1; then go to RF_REQ.
- RF_REQ:
  - mem_rd_req=1; mem_rd_addr = {latched tag, index, 0}.
  - Held until mem_rd_ready; then counter=0, go to RF_DATA.
- RF_DATA:
  - Each mem_rd_valid cycle: line_buf[counter] <= mem_rd_data; counter++.
  - Gaps (mem_rd_valid=0) are allowed.
  - The beat with counter==WPL-1 moves to REFILL. Counter wraps to 0.
- REFILL (single cycle):
  - Store: merge wstrb/wdata into the addressed word of line_buf.
  - ram_we all ones; ram_dina = merged line.
  - ram_wen=1, ram_tag_w = latched tag.
  - ram_wen_dv=1, w_valid=1, w_dirty=req_wr.
  - resp_valid=1; resp_rdata = addressed word of line_buf (load) or 0 (store).
  - Go to IDLE.
- Throughput: at most one request per 2 cycles. A request arriving the cycle after resp_valid sees the updated RAM. The RAM writes at the edge that ends REFILL / store-hit, before the next LOOKUP.
- Only one memory request is outstanding at a time. mem_wr_req and mem_rd_req are never high together.

Test Plan:
- Clean read miss:
  - Stimulus: after reset, load 0x0000_1040; memory returns words 0xA0..0xA7 with one idle gap.
  - Response: mem_rd_addr=0x0000_1040, no mem_wr_req. REFILL writes index 0x02 with tag 0x00001, valid=1, dirty=0. resp_rdata=0xA0.
- Read hit:
  - Stimulus: then load 0x0000_104C.
  - Response: resp_valid exactly 1 cycle after acceptance, rdata=0xA3, no memory traffic.
- Store hit:
  - Stimulus: store 0x0000_1044, wstrb=4'b0011, wdata=0x1234_5678.
  - Response: ram_we bits 4,5 only; w_dirty=1. A following load of 0x0000_1044 returns 0x0000_5678 (upper bytes of 0xA1 = 0).
- Dirty eviction:
  - Stimulus: load 0x0000_2040 (same index 0x02, tag 0x00002); hold mem_wr_ready low for 3 cycles.
  - Response: mem_wr_addr=0x0000_1040 and mem_wr_data are stable through the stall, then the refill request goes to 0x0000_2040. The new line ends clean.
- Store miss:
  - Stimulus: store to 0x0000_3000 (clean victim).
  - Response: refill, then the REFILL write has the merged word. Tag 0x00003, valid=1, dirty=1.
- Reset mid-refill:
  - Stimulus: assert reset after 4 beats of RF_DATA.
  - Response: next cycle IDLE, req_ready=1, no ram_wen/ram_wen_dv pulse, mem_rd_req=0.
